// File: rtl/rename_stage_pkg.sv
// rtl/rename_stage_pkg.sv - shared types, sizes and opcode constants for the rename stage
package rename_pkg;

  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = 6;
  localparam int FL_DEPTH  = NUM_PREGS - 32;
  localparam int FL_IDX_W  = $clog2(FL_DEPTH);
  // One extra wrap bit so a full list (tail-head == FL_DEPTH) differs from an empty one
  localparam int PTR_W     = FL_IDX_W + 1;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] pc;
    preg_t       prs1;
    preg_t       prs2;
    preg_t       prd;
    preg_t       old_prd;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  alu_op;
    logic [6:0]  opcode;
  } renamed_t;

  function automatic logic writes_rd(input logic [4:0] rd, input logic [6:0] opcode);
    logic op_writes;
    op_writes = (opcode == OPC_OP)  || (opcode == OPC_OP_IMM) || (opcode == OPC_LOAD) ||
                (opcode == OPC_LUI) || (opcode == OPC_AUIPC)  || (opcode == OPC_JAL)  ||
                (opcode == OPC_JALR);
    return (rd != 5'd0) && op_writes;
  endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// rtl/rename_stage_free_list.sv - circular physical-register free list with committed head for flush recovery
module free_list
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  alloc,
  input  logic  push,
  input  preg_t push_preg,
  input  logic  restore,
  output preg_t alloc_preg,
  output logic  empty
);

  preg_t   fl_q [FL_DEPTH];
  preg_t   fl_d [FL_DEPTH];
  fl_ptr_t head_q, head_d;
  fl_ptr_t commit_head_q, commit_head_d;
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t count;
  logic    full;

  assign count      = tail_q - head_q;
  assign empty      = (count == '0);
  assign full       = (count == PTR_W'(FL_DEPTH));
  assign alloc_preg = fl_q[head_q[FL_IDX_W-1:0]];

  always_comb begin
    fl_d          = fl_q;
    tail_d        = tail_q;
    commit_head_d = commit_head_q;
    head_d        = head_q;
    // Every retiring writer consumed exactly one entry, so commit_head advances with each push
    if (push) begin
      fl_d[tail_q[FL_IDX_W-1:0]] = push_preg;
      tail_d        = tail_q + PTR_W'(1);
      commit_head_d = commit_head_q + PTR_W'(1);
    end
    if (restore) begin
      head_d = commit_head_d;
    end else if (alloc) begin
      head_d = head_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= preg_t'(32 + i);
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_W'(FL_DEPTH);
    end else begin
      fl_q          <= fl_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - single-issue register rename with speculative/committed maps and one-cycle flush recovery
module rename_stage
  import rename_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [31:0]       pc_in,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  input  logic [2:0]        ALUOp,
  input  logic [6:0]        opcode,
  input  logic              ready_out,
  output logic              valid_out,
  output logic [31:0]       pc_out,
  output logic [PREG_W-1:0] prs1,
  output logic [PREG_W-1:0] prs2,
  output logic [PREG_W-1:0] prd,
  output logic [PREG_W-1:0] old_prd,
  output logic              rd_we,
  output logic [4:0]        rd_out,
  output logic [31:0]       imm_out,
  output logic [2:0]        ALUOp_out,
  output logic [6:0]        opcode_out,
  input  logic              commit_valid,
  input  logic [4:0]        commit_areg,
  input  logic [PREG_W-1:0] commit_preg,
  input  logic [PREG_W-1:0] commit_old_preg,
  input  logic              flush
);

  preg_t    spec_map_q [32];
  preg_t    spec_map_d [32];
  preg_t    committed_map_q [32];
  preg_t    committed_map_d [32];
  renamed_t slot_q, slot_d;
  logic     valid_q, valid_d;
  logic     wr;
  logic     accept;
  logic     fl_empty;
  preg_t    fl_alloc_preg;

  free_list u_free_list (
    .clk        (clk),
    .reset      (reset),
    .alloc      (accept && wr),
    .push       (commit_valid),
    .push_preg  (commit_old_preg),
    .restore    (flush),
    .alloc_preg (fl_alloc_preg),
    .empty      (fl_empty)
  );

  always_comb begin
    wr       = writes_rd(rd, opcode);
    ready_in = (ready_out || !valid_q) && !(wr && fl_empty) && !flush;
    accept   = valid_in && ready_in;

    committed_map_d = committed_map_q;
    if (commit_valid) begin
      committed_map_d[commit_areg] = commit_preg;
    end

    // Flush restores from the committed view including this cycle's retirement
    spec_map_d = spec_map_q;
    if (flush) begin
      spec_map_d = committed_map_d;
    end else if (accept && wr) begin
      spec_map_d[rd] = fl_alloc_preg;
    end

    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d        = 1'b1;
      slot_d.pc      = pc_in;
      slot_d.prs1    = spec_map_q[rs1];
      slot_d.prs2    = spec_map_q[rs2];
      slot_d.prd     = wr ? fl_alloc_preg : '0;
      slot_d.old_prd = wr ? spec_map_q[rd] : '0;
      slot_d.rd_we   = wr;
      slot_d.rd      = rd;
      slot_d.imm     = imm;
      slot_d.alu_op  = ALUOp;
      slot_d.opcode  = opcode;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        spec_map_q[i]      <= preg_t'(i);
        committed_map_q[i] <= preg_t'(i);
      end
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      spec_map_q      <= spec_map_d;
      committed_map_q <= committed_map_d;
      slot_q          <= slot_d;
      valid_q         <= valid_d;
    end
  end

  assign valid_out  = valid_q;
  assign pc_out     = slot_q.pc;
  assign prs1       = slot_q.prs1;
  assign prs2       = slot_q.prs2;
  assign prd        = slot_q.prd;
  assign old_prd    = slot_q.old_prd;
  assign rd_we      = slot_q.rd_we;
  assign rd_out     = slot_q.rd;
  assign imm_out    = slot_q.imm;
  assign ALUOp_out  = slot_q.alu_op;
  assign opcode_out = slot_q.opcode;

endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - directed and randomized checks of rename_stage against a queue-based model
module tb_rename_stage;
  import rename_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, valid_in, ready_in, ready_out, valid_out, rd_we;
  logic [31:0] pc_in, imm, pc_out, imm_out;
  logic [4:0]  rs1, rs2, rd, rd_out, commit_areg;
  logic [2:0]  ALUOp, ALUOp_out;
  logic [6:0]  opcode, opcode_out;
  preg_t       prs1, prs2, prd, old_prd, commit_preg, commit_old_preg;
  logic        commit_valid, flush;

  rename_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .pc_in(pc_in), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ALUOp(ALUOp),
    .opcode(opcode), .ready_out(ready_out), .valid_out(valid_out), .pc_out(pc_out),
    .prs1(prs1), .prs2(prs2), .prd(prd), .old_prd(old_prd), .rd_we(rd_we),
    .rd_out(rd_out), .imm_out(imm_out), .ALUOp_out(ALUOp_out), .opcode_out(opcode_out),
    .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_preg(commit_preg),
    .commit_old_preg(commit_old_preg), .flush(flush)
  );

  int checks = 0;
  int failures = 0;

  // Model: free regs as an ordered queue, renamed-but-unretired writers as a ROB queue
  typedef struct { logic [4:0] areg; preg_t preg; preg_t old; } rob_t;
  preg_t smap [32];
  preg_t cmap [32];
  preg_t free_q [$];
  rob_t  rob_q [$];
  logic  m_valid, m_ready, obs_ready;
  logic [31:0] e_pc, e_imm;
  preg_t e_prs1, e_prs2, e_prd, e_old;
  logic  e_we;
  logic [4:0] e_rd;
  logic [2:0] e_alu;
  logic [6:0] e_opc;

  function automatic logic m_writes(logic [4:0] r, logic [6:0] o);
    return (r != 0) && (o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                  7'b0010111, 7'b1101111, 7'b1100111});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      smap[i] = preg_t'(i);
      cmap[i] = preg_t'(i);
    end
    free_q.delete();
    for (int i = 32; i < 64; i++) free_q.push_back(preg_t'(i));
    rob_q.delete();
    m_valid = 0;
    {e_pc, e_imm, e_prs1, e_prs2, e_prd, e_old, e_we, e_rd, e_alu, e_opc} = '0;
  endtask

  // Advance one clock: sample ready_in, update the model from the driven inputs, then settle
  task automatic tick();
    logic wr, acc;
    #1;
    obs_ready = ready_in;
    wr = m_writes(rd, opcode);
    m_ready = (ready_out || !m_valid) && !(wr && free_q.size() == 0) && !flush;
    acc = valid_in && m_ready;
    if (reset) begin
      model_reset();
    end else begin
      if (acc) begin
        e_prs1 = smap[rs1];
        e_prs2 = smap[rs2];
        if (wr) begin
          e_prd = free_q.pop_front();
          e_old = smap[rd];
          smap[rd] = e_prd;
          rob_q.push_back('{rd, e_prd, e_old});
        end else begin
          e_prd = 0;
          e_old = 0;
        end
        e_we = wr; e_pc = pc_in; e_rd = rd; e_imm = imm; e_alu = ALUOp; e_opc = opcode;
        m_valid = 1;
      end else if (ready_out) begin
        m_valid = 0;
      end
      if (commit_valid) begin
        cmap[commit_areg] = commit_preg;
        free_q.push_back(commit_old_preg);
        if (rob_q.size() > 0) void'(rob_q.pop_front());
      end
      if (flush) begin
        smap = cmap;
        for (int i = rob_q.size() - 1; i >= 0; i--) free_q.push_front(rob_q[i].preg);
        rob_q.delete();
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic v, logic [4:0] d, logic [4:0] s1, logic [4:0] s2, logic [6:0] opc);
    valid_in = v; rd = d; rs1 = s1; rs2 = s2; opcode = opc;
    pc_in = $urandom; imm = $urandom; ALUOp = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    reset = 1; valid_in = 0; commit_valid = 0; flush = 0; ready_out = 1;
    commit_areg = 0; commit_preg = 0; commit_old_preg = 0;
    set_in(0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    set_in(0, 5, 1, 2, OPC_OP);
    #1;
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
    checks++;
    if ({pc_out, prs1, prs2, prd, old_prd, rd_we, imm_out} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {pc_out, prs1, prs2, prd, old_prd, rd_we, imm_out});
    end
    checks++;
    if (ready_in !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", ready_in); end
  endtask

  task automatic test_basic();
    do_reset();
    set_in(1, 5, 1, 2, OPC_OP);
    tick();
    checks++;
    if ({valid_out, prs1, prs2, prd, old_prd, rd_we} !== {1'b1, 6'd1, 6'd2, 6'd32, 6'd5, 1'b1}) begin
      failures++; $display("FAIL add_rename got v=%0b %0d %0d %0d %0d we=%0b exp v=1 1 2 32 5 we=1",
                           valid_out, prs1, prs2, prd, old_prd, rd_we);
    end
    checks++;
    if ({pc_out, imm_out, ALUOp_out, opcode_out, rd_out} !== {e_pc, e_imm, e_alu, OPC_OP, 5'd5}) begin
      failures++; $display("FAIL add_passthru got pc=%h imm=%h exp pc=%h imm=%h", pc_out, imm_out, e_pc, e_imm);
    end
    set_in(1, 6, 5, 0, OPC_OP_IMM);
    tick();
    checks++;
    if ({prs1, prs2, prd, old_prd} !== {6'd32, 6'd0, 6'd33, 6'd6}) begin
      failures++; $display("FAIL addi_dep got %0d %0d %0d %0d exp 32 0 33 6", prs1, prs2, prd, old_prd);
    end
  endtask

  task automatic test_no_write();
    set_in(1, 7, 1, 5, OPC_STORE);
    tick();
    checks++;
    if ({valid_out, prd, old_prd, rd_we, opcode_out, prs2} !== {1'b1, 6'd0, 6'd0, 1'b0, OPC_STORE, 6'd32}) begin
      failures++; $display("FAIL store got v=%0b prd=%0d old=%0d we=%0b opc=%b exp v=1 0 0 0 %b",
                           valid_out, prd, old_prd, rd_we, opcode_out, OPC_STORE);
    end
    set_in(1, 9, 5, 6, OPC_BRANCH);
    tick();
    checks++;
    if ({valid_out, prd, rd_we, opcode_out, prs1, prs2} !== {1'b1, 6'd0, 1'b0, OPC_BRANCH, 6'd32, 6'd33}) begin
      failures++; $display("FAIL branch got v=%0b prd=%0d we=%0b opc=%b exp v=1 0 0 %b",
                           valid_out, prd, rd_we, opcode_out, OPC_BRANCH);
    end
    set_in(1, 8, 0, 0, OPC_LUI);
    tick();
    checks++;
    if (prd !== 6'd34) begin failures++; $display("FAIL after_store_head got=%0d exp=34", prd); end
  endtask

  task automatic test_free_empty();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_in(1, (i == 0) ? 5'd5 : 5'(1 + (i % 31)), 0, 0, OPC_OP);
      tick();
    end
    checks++;
    if (prd !== 6'd63) begin failures++; $display("FAIL last_alloc got=%0d exp=63", prd); end
    set_in(1, 10, 3, 4, OPC_OP);
    tick();
    checks++;
    if ({obs_ready, valid_out} !== 2'b00) begin
      failures++; $display("FAIL empty_stall got ready=%0b valid=%0b exp 0 0", obs_ready, valid_out);
    end
    commit_valid = 1; commit_areg = 5; commit_preg = 32; commit_old_preg = 5;
    tick();
    commit_valid = 0;
    checks++;
    if (obs_ready !== 1'b0) begin failures++; $display("FAIL push_same_cycle got=%0b exp=0", obs_ready); end
    tick();
    checks++;
    if ({obs_ready, valid_out, prd} !== {1'b1, 1'b1, 6'd5}) begin
      failures++; $display("FAIL refill got ready=%0b valid=%0b prd=%0d exp 1 1 5", obs_ready, valid_out, prd);
    end
  endtask

  task automatic test_stall();
    logic [31:0] first_pc;
    do_reset();
    set_in(1, 3, 1, 2, OPC_OP);
    first_pc = pc_in;
    tick();
    ready_out = 0;
    set_in(1, 4, 3, 0, OPC_OP);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({obs_ready, valid_out, pc_out, prd} !== {1'b0, 1'b1, first_pc, 6'd32}) begin
        failures++; $display("FAIL stall_hold cyc=%0d got ready=%0b v=%0b pc=%h prd=%0d exp 0 1 %h 32",
                             i, obs_ready, valid_out, pc_out, prd, first_pc);
      end
    end
    ready_out = 1;
    tick();
    checks++;
    if ({obs_ready, valid_out, pc_out, prs1, prd} !== {1'b1, 1'b1, e_pc, 6'd32, 6'd33}) begin
      failures++; $display("FAIL stall_release got ready=%0b v=%0b prs1=%0d prd=%0d exp 1 1 32 33",
                           obs_ready, valid_out, prs1, prd);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 5, 0, 0, OPC_OP);
    tick();
    set_in(1, 5, 0, 0, OPC_OP);
    tick();
    commit_valid = 1; commit_areg = 5; commit_preg = 32; commit_old_preg = 5;
    flush = 1;
    set_in(1, 5, 0, 0, OPC_OP);
    tick();
    commit_valid = 0; flush = 0;
    checks++;
    if ({obs_ready, valid_out} !== 2'b00) begin
      failures++; $display("FAIL flush_drop got ready=%0b valid=%0b exp 0 0", obs_ready, valid_out);
    end
    set_in(1, 5, 5, 0, OPC_OP);
    tick();
    checks++;
    if ({prd, old_prd, prs1} !== {6'd33, 6'd32, 6'd32}) begin
      failures++; $display("FAIL flush_restore got prd=%0d old=%0d prs1=%0d exp 33 32 32", prd, old_prd, prs1);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs [10];
    opcs = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
             OPC_STORE, OPC_BRANCH, 7'b1110011};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), opcs[$urandom_range(0, 9)]);
      ready_out = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
      reset = (c == 300);
      commit_valid = (rob_q.size() > 0) && ($urandom_range(0, 2) == 0);
      if (commit_valid) begin
        commit_areg = rob_q[0].areg; commit_preg = rob_q[0].preg; commit_old_preg = rob_q[0].old;
      end
      tick();
      checks++;
      if ({obs_ready, valid_out} !== {m_ready, m_valid}) begin
        failures++; $display("FAIL rand_handshake cyc=%0d got ready=%0b v=%0b exp %0b %0b",
                             c, obs_ready, valid_out, m_ready, m_valid);
      end
      if (m_valid) begin
        checks++;
        if ({pc_out, prs1, prs2, prd, old_prd, rd_we, rd_out, imm_out, ALUOp_out, opcode_out} !==
            {e_pc, e_prs1, e_prs2, e_prd, e_old, e_we, e_rd, e_imm, e_alu, e_opc}) begin
          failures++; $display("FAIL rand_slot cyc=%0d got %0d %0d %0d %0d we=%0b exp %0d %0d %0d %0d we=%0b",
                               c, prs1, prs2, prd, old_prd, rd_we, e_prs1, e_prs2, e_prd, e_old, e_we);
        end
      end
    end
    reset = 0; flush = 0; commit_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_write();
    test_free_empty();
    test_stall();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Single-issue register rename stage directly downstream of decode in the out-of-order RISC-V core.
- Accepts one decoded instruction per cycle over valid/ready and maps architectural sources to physical registers via a speculative map table.
- Allocates a physical destination from a circular free list and presents the renamed instruction in a registered output slot for dispatch/ROB.
- Keeps a committed map table and committed free-list head so that a flush restores precise rename state in one cycle.

Parameters:
NUM_PREGS, 64, physical register count (>32, power of two)
PREG_W, 6, log2(NUM_PREGS)
FL_DEPTH, 32, free-list entries = NUM_PREGS-32

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
valid_in  in  1  decoded instruction valid
ready_in  out  1  rename can accept
pc_in  in  32  instruction PC
rs1  in  5  arch source 1
rs2  in  5  arch source 2
rd  in  5  arch destination
imm  in  32  immediate
ALUOp  in  3  ALU op class
opcode  in  7  RISC-V opcode
ready_out  in  1  dispatch can accept
valid_out  out  1  renamed slot valid
pc_out  out  32  registered PC
prs1  out  PREG_W  physical source 1
prs2  out  PREG_W  physical source 2
prd  out  PREG_W  allocated physical dest (0 when no write)
old_prd  out  PREG_W  previous mapping of rd (for ROB free-on-commit)
rd_we  out  1  instruction writes a non-x0 destination
rd_out  out  5  arch destination passthrough
imm_out  out  32  passthrough
ALUOp_out  out  3  passthrough
opcode_out  out  7  passthrough
commit_valid  in  1  ROB retiring an instruction with rd_we=1
commit_areg  in  5  retiring arch dest
commit_preg  in  PREG_W  retiring physical dest
commit_old_preg  in  PREG_W  physical reg to return to free list
flush  in  1  mispredict/exception recovery

Behaviour:
- Reset: spec_map[i]=committed_map[i]=i for i=0..31. Free list slots 0..31 hold p32..p63. head=0, commit_head=0, tail=FL_DEPTH (pointers PREG_W bits, wrap modulo 2*FL_DEPTH). valid_out=0. All data outputs=0.
- Writes-rd decode: rd!=0 and opcode in {0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111}. STORE and BRANCH never write.
- count = tail-head. free_empty = (count==0).
- ready_in = (ready_out || !valid_out) && !(writes_rd && free_empty) && !flush. Depends combinationally on the input rd/opcode; this is intended.
- Accept (valid_in && ready_in): 1-cycle latency.
  - prs1=spec_map[rs1], prs2=spec_map[rs2], read before this cycle's update; rs=0 yields p0.
  - If writes_rd: prd=fl[head], old_prd=spec_map[rd], spec_map[rd]<=prd, head++.
  - Else prd=0, old_prd=0, rd_we=0, map unchanged.
  - valid_out<=1; passthroughs registered.
- Back-to-back dependents rename correctly because the map updates at the accept edge.
- Drain: ready_out && valid_out with no accept -> valid_out<=0. Output slot holds stable while valid_out && !ready_out.
- Commit (independent of upstream handshake):
  - committed_map[commit_areg]<=commit_preg.
  - fl[tail]<=commit_old_preg, tail++, commit_head++.
  - A pushed reg is allocatable from the next cycle only.
- Flush (priority over accept; commit in the same cycle still applies first):
  - spec_map<=committed_map with the same-cycle commit merged.
  - head<=commit_head post-increment.
  - valid_out<=0; input dropped.
- Invariants: count never exceeds FL_DEPTH; p0 is never allocated or freed. Assertion flags commit_valid with count==FL_DEPTH.
- Reset mid-operation restores the full reset state; in-flight commits are lost.

Decomposition:
- Shared package rename_pkg: NUM_PREGS, PREG_W, FL_DEPTH; preg_t typedef; opcode constants (OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR, STORE, BRANCH); renamed-instruction struct.
- One sub-module, free_list, owns the fl array, head/commit_head/tail and alloc/push/restore. Map tables stay in rename_stage.

Test Plan:
- Reset, then add x5,x1,x2 (opcode 0110011, rd=5) -> next cycle prs1=1, prs2=2, prd=32, old_prd=5, rd_we=1, valid_out=1.
- Follow with addi x6,x5,1 back-to-back -> prs1=32, prd=33, old_prd=6.
- Store sw x5,0(x1), then beq -> prd=0, rd_we=0, head unchanged, both presented in order.
- 32 dest-writing instructions with no commits -> the 33rd sees ready_in=0. Commit old_prd=5 -> ready_in=1 next cycle, 33rd gets prd=5.
- Hold ready_out=0 with valid_out=1 for 3 cycles -> outputs stable, ready_in=0. Release -> drains, accepts next.
- Rename x5->p32, x5->p33; commit the first (areg 5, preg 32, old 5) in the same cycle as flush -> spec_map[5]=32, next x5 writer gets p33 again, valid_out=0 after flush.
